button_debounce: RTL and testbench

Synchronizes, debounces and classifies the raw board push-button before it reaches the PLL-clocked logic, so the button feeding the LED/counter reset is a clean, glitch-free level. It runs on the PLL output clock. It produces a debounced level plus single-cycle press, release, click and long-press events. Downstream logic consumes `pressed` as a reset/enable term and the pulses as user commands.

---
 rtl/button_pkg.sv | 14 +
 rtl/sync_2ff.sv | 23 ++
 rtl/button_debounce.sv | 152 +++++++++++++++
 tb/tb_button_debounce.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared encodings and helpers for the push-button front end.
package button_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    LONG = 2'd2
  } state_t;

  function automatic int ms_to_cycles(input int clk_hz, input int ms);
    return clk_hz / 1000 * ms;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous pad inputs.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_debounce.sv
// Push-button synchronizer, debouncer and press/release/click/long classifier.
//   state | meaning
//   IDLE  | debounced button released
//   HELD  | debounced button held, long threshold not yet reached
//   LONG  | held past the long threshold, long_pulse already issued
module button_debounce
  import button_pkg::*;
#(
  parameter int CLK_HZ      = 10_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000
) (
  input  logic clock,
  input  logic reset,
  input  logic button_n,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic click_pulse,
  output logic long_pulse
);

  localparam int DEB_CYCLES  = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
  localparam int LONG_CYCLES = ms_to_cycles(CLK_HZ, LONG_MS);
  localparam int DEB_W       = $clog2(DEB_CYCLES);
  localparam int HOLD_W      = $clog2(LONG_CYCLES);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

  if (DEB_CYCLES < 2) begin : g_deb_check
    $error("button_debounce: DEB_CYCLES must be at least 2");
  end
  if (LONG_CYCLES <= DEB_CYCLES) begin : g_long_check
    $error("button_debounce: LONG_CYCLES must exceed DEB_CYCLES");
  end

  logic              button_sync_n;
  logic              sync_press;
  logic              differ;
  logic              deb_done;
  logic              rise;
  logic              fall;
  logic [DEB_W-1:0]  deb_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_next;
  state_t            state;
  state_t            state_next;
  logic              press_d;
  logic              release_d;
  logic              click_d;
  logic              long_d;

  // Reset to released so a button held through reset is seen as a new press.
  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clock(clock),
    .reset(reset),
    .d    (button_n),
    .q    (button_sync_n)
  );

  assign sync_press = ~button_sync_n;
  assign differ     = sync_press != pressed;
  assign deb_done   = differ && (deb_cnt == DEB_LAST);
  assign rise       = deb_done && sync_press;
  assign fall       = deb_done && !sync_press;

  always_ff @(posedge clock) begin
    if (reset) begin
      deb_cnt <= '0;
      pressed <= 1'b0;
    end else begin
      if (!differ || deb_done) begin
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + DEB_W'(1);
      end
      if (deb_done) begin
        pressed <= ~pressed;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      hold_cnt      <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      click_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
    end else begin
      state         <= state_next;
      hold_cnt      <= hold_next;
      press_pulse   <= press_d;
      release_pulse <= release_d;
      click_pulse   <= click_d;
      long_pulse    <= long_d;
    end
  end

  always_comb begin
    state_next = state;
    hold_next  = hold_cnt;
    case (state)
      IDLE: begin
        hold_next = '0;
        if (rise) begin
          state_next = HELD;
        end
      end
      HELD: begin
        if (fall) begin
          state_next = IDLE;
        end else if (hold_cnt == HOLD_LAST) begin
          state_next = LONG;
        end else begin
          hold_next = hold_cnt + HOLD_W'(1);
        end
      end
      LONG: begin
        if (fall) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        hold_next  = '0;
      end
    endcase
  end

  // A release landing on the long threshold counts as a click.
  always_comb begin
    press_d   = 1'b0;
    release_d = 1'b0;
    click_d   = 1'b0;
    long_d    = 1'b0;
    case (state)
      IDLE: press_d = rise;
      HELD: begin
        release_d = fall;
        click_d   = fall;
        long_d    = !fall && (hold_cnt == HOLD_LAST);
      end
      LONG: release_d = fall;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_button_debounce.sv
// Randomized and directed bench for button_debounce against a timing-rule reference model.
module tb_button_debounce;

  localparam int CLK_HZ      = 1000;
  localparam int DEBOUNCE_MS = 4;
  localparam int LONG_MS     = 20;
  localparam int DEB         = 4;
  localparam int LONG_C      = 20;

  logic clock    = 1'b0;
  logic reset    = 1'b1;
  logic button_n = 1'b1;
  logic pressed, press_pulse, release_pulse, click_pulse, long_pulse;

  int total = 0;
  int bad   = 0;

  button_debounce #(
    .CLK_HZ     (CLK_HZ),
    .DEBOUNCE_MS(DEBOUNCE_MS),
    .LONG_MS    (LONG_MS)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .button_n     (button_n),
    .pressed      (pressed),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .click_pulse  (click_pulse),
    .long_pulse   (long_pulse)
  );

  always #5 clock = ~clock;

  // Reference: pad delayed two cycles, level flips once DEB consecutive
  // samples disagree with it, long fires LONG_C cycles after the press.
  bit m_s1 = 1'b1;
  bit m_s2 = 1'b1;
  bit m_hist[$];
  bit m_pressed, m_press, m_rel, m_click, m_long, m_long_done;
  int m_cyc = 0;
  int m_press_cyc = 0;

  always @(posedge clock) begin
    bit sp;
    bit all_diff;
    m_cyc++;
    m_press = 0; m_rel = 0; m_click = 0; m_long = 0;
    if (reset) begin
      m_s1 = 1; m_s2 = 1;
      m_hist.delete();
      m_pressed = 0;
      m_long_done = 0;
    end else begin
      sp = ~m_s2;
      m_s2 = m_s1;
      m_s1 = button_n;
      m_hist.push_back(sp);
      if (m_hist.size() > DEB) void'(m_hist.pop_front());
      all_diff = (m_hist.size() == DEB);
      foreach (m_hist[i]) if (m_hist[i] == m_pressed) all_diff = 0;
      if (all_diff) begin
        m_hist.delete();
        m_pressed = ~m_pressed;
        if (m_pressed) begin
          m_press = 1;
          m_press_cyc = m_cyc;
          m_long_done = 0;
        end else begin
          m_rel = 1;
          m_click = !m_long_done;
        end
      end else if (m_pressed && !m_long_done && (m_cyc - m_press_cyc == LONG_C)) begin
        m_long = 1;
        m_long_done = 1;
      end
    end
  end

  logic [4:0] obs_v, exp_v;
  assign obs_v = {pressed, press_pulse, release_pulse, click_pulse, long_pulse};
  assign exp_v = {m_pressed, m_press, m_rel, m_click, m_long};

  task automatic test_reset();
    int pr_at = -1;
    reset = 1; button_n = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      total++;
      if (obs_v !== 5'b0) begin
        bad++; $display("FAIL reset_outputs cyc=%0d got=%b want=00000", i, obs_v);
      end
    end
    reset = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      total++;
      if (obs_v !== exp_v) begin
        bad++; $display("FAIL reset_model cyc=%0d got=%b want=%b", i, obs_v, exp_v);
      end
      if (press_pulse && pr_at < 0) pr_at = i;
    end
    total++;
    if (pr_at !== 5) begin
      bad++; $display("FAIL reset_repress_edge got=%0d want=5", pr_at);
    end
    button_n = 1;
    for (int i = 0; i < 12; i++) @(negedge clock);
  endtask

  task automatic test_clean_press();
    int pr_at = -1, rel_at = -1, clk_at = -1, longs = 0;
    for (int i = 0; i < 25; i++) begin
      button_n = (i < 10) ? 1'b0 : 1'b1;
      @(negedge clock);
      total++;
      if (obs_v !== exp_v) begin
        bad++; $display("FAIL clean_model cyc=%0d got=%b want=%b", i, obs_v, exp_v);
      end
      if (press_pulse && pr_at < 0) pr_at = i;
      if (release_pulse && rel_at < 0) rel_at = i;
      if (click_pulse && clk_at < 0) clk_at = i;
      if (long_pulse) longs++;
    end
    total++;
    if (pr_at !== 5) begin bad++; $display("FAIL clean_press_edge got=%0d want=5", pr_at); end
    total++;
    if (rel_at !== 15) begin bad++; $display("FAIL clean_release_edge got=%0d want=15", rel_at); end
    total++;
    if (clk_at !== 15) begin bad++; $display("FAIL clean_click_edge got=%0d want=15", clk_at); end
    total++;
    if (longs !== 0) begin bad++; $display("FAIL clean_no_long got=%0d want=0", longs); end
  endtask

  task automatic test_bounce();
    int pr_at = -1, early = 0;
    for (int i = 0; i < 30; i++) begin
      button_n = (i < 12) ? i[1] : 1'b0;
      @(negedge clock);
      total++;
      if (obs_v !== exp_v) begin
        bad++; $display("FAIL bounce_model cyc=%0d got=%b want=%b", i, obs_v, exp_v);
      end
      if (i < 17 && obs_v !== 5'b0) early++;
      if (press_pulse && pr_at < 0) pr_at = i;
    end
    total++;
    if (early !== 0) begin bad++; $display("FAIL bounce_quiet got=%0d want=0", early); end
    total++;
    if (pr_at !== 17) begin bad++; $display("FAIL bounce_press_edge got=%0d want=17", pr_at); end
    button_n = 1;
    for (int i = 0; i < 12; i++) @(negedge clock);
  endtask

  task automatic test_long_press();
    int pr_at = -1, lg_at = -1, longs = 0, clicks = 0, rel_at = -1;
    for (int i = 0; i < 55; i++) begin
      button_n = (i < 40) ? 1'b0 : 1'b1;
      @(negedge clock);
      total++;
      if (obs_v !== exp_v) begin
        bad++; $display("FAIL long_model cyc=%0d got=%b want=%b", i, obs_v, exp_v);
      end
      if (press_pulse && pr_at < 0) pr_at = i;
      if (long_pulse) begin longs++; if (lg_at < 0) lg_at = i; end
      if (click_pulse) clicks++;
      if (release_pulse && rel_at < 0) rel_at = i;
    end
    total++;
    if (lg_at - pr_at !== LONG_C) begin
      bad++; $display("FAIL long_delay got=%0d want=%0d", lg_at - pr_at, LONG_C);
    end
    total++;
    if (longs !== 1) begin bad++; $display("FAIL long_once got=%0d want=1", longs); end
    total++;
    if (clicks !== 0 || rel_at !== 45) begin
      bad++; $display("FAIL long_release got=click%0d/rel%0d want=click0/rel45", clicks, rel_at);
    end
  endtask

  task automatic test_tie();
    int rel_at = -1, clk_at = -1, longs = 0;
    for (int i = 0; i < 36; i++) begin
      button_n = (i < 20) ? 1'b0 : 1'b1;
      @(negedge clock);
      total++;
      if (obs_v !== exp_v) begin
        bad++; $display("FAIL tie_model cyc=%0d got=%b want=%b", i, obs_v, exp_v);
      end
      if (release_pulse && rel_at < 0) rel_at = i;
      if (click_pulse && clk_at < 0) clk_at = i;
      if (long_pulse) longs++;
    end
    total++;
    if (rel_at !== 25 || clk_at !== 25 || longs !== 0) begin
      bad++; $display("FAIL tie_release_wins got=rel%0d/click%0d/long%0d want=rel25/click25/long0",
                      rel_at, clk_at, longs);
    end
  endtask

  task automatic test_reset_mid_hold();
    int rels = 0, pr_at = -1;
    for (int i = 0; i < 30; i++) begin
      button_n = 1'b0;
      reset = (i >= 10 && i < 13);
      @(negedge clock);
      total++;
      if (obs_v !== exp_v) begin
        bad++; $display("FAIL midrst_model cyc=%0d got=%b want=%b", i, obs_v, exp_v);
      end
      if (i >= 10 && i < 13) begin
        total++;
        if (obs_v !== 5'b0) begin
          bad++; $display("FAIL midrst_outputs cyc=%0d got=%b want=00000", i, obs_v);
        end
      end
      if (release_pulse) rels++;
      if (i >= 13 && press_pulse && pr_at < 0) pr_at = i;
    end
    reset = 0;
    total++;
    if (rels !== 0) begin bad++; $display("FAIL midrst_no_release got=%0d want=0", rels); end
    total++;
    if (pr_at !== 18) begin bad++; $display("FAIL midrst_repress_edge got=%0d want=18", pr_at); end
    button_n = 1;
    for (int i = 0; i < 12; i++) @(negedge clock);
  endtask

  task automatic test_glitch();
    int changes = 0, held_rel = 0;
    for (int i = 0; i < 20; i++) begin
      button_n = (i < 3) ? 1'b0 : 1'b1;
      @(negedge clock);
      total++;
      if (obs_v !== exp_v) begin
        bad++; $display("FAIL glitch_model cyc=%0d got=%b want=%b", i, obs_v, exp_v);
      end
      if (obs_v !== 5'b0) changes++;
    end
    total++;
    if (changes !== 0) begin bad++; $display("FAIL glitch_idle got=%0d want=0", changes); end
    for (int i = 0; i < 40; i++) begin
      button_n = (i >= 12 && i < 15) || (i >= 25) ? 1'b1 : 1'b0;
      @(negedge clock);
      total++;
      if (obs_v !== exp_v) begin
        bad++; $display("FAIL glitch_held_model cyc=%0d got=%b want=%b", i, obs_v, exp_v);
      end
      if (i >= 5 && i < 25 && (!pressed || release_pulse)) held_rel++;
    end
    total++;
    if (held_rel !== 0) begin bad++; $display("FAIL glitch_held got=%0d want=0", held_rel); end
  endtask

  task automatic test_random();
    for (int seg = 0; seg < 80; seg++) begin
      int   len;
      logic lvl;
      bit   do_rst;
      len    = $urandom_range(1, 30);
      lvl    = 1'($urandom_range(0, 1));
      do_rst = ($urandom_range(0, 19) == 0);
      for (int i = 0; i < len; i++) begin
        button_n = lvl;
        reset    = do_rst && (i < 2);
        @(negedge clock);
        total++;
        if (obs_v !== exp_v) begin
          bad++; $display("FAIL random_model seg=%0d cyc=%0d got=%b want=%b", seg, i, obs_v, exp_v);
        end
      end
    end
    reset = 0;
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_press();
    test_tie();
    test_reset_mid_hold();
    test_glitch();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
